rect_draw_sequencer: RTL and testbench
======================================

// Module: rect_draw_sequencer
// PURPOSE
//  Shares the video-memory write port (x, y, colour, plot) of the VGA adaptor between NREQ drawing clients.
//  Each client posts one filled-rectangle command; a round-robin arbiter grants one command at a time.
//  The sequencer then scans the rectangle row-major and emits one pixel write per clock.
//  Sits between game logic (quadrant flash, clear screen, score bar) and the adaptor's write port.
// PARAMETERS
//  NREQ         2    number of requesting clients (2..4)
//  nX           8    x coordinate width
//  nY           7    y coordinate width
//  COLOR_DEPTH  6    pixel colour width (matches video memory)
//  COLS         160  screen columns; writes with x >= COLS are suppressed
//  ROWS         120  screen rows; writes with y >= ROWS are suppressed
// PORTS
//  clock       in   1                 system clock (same clock as adaptor write port)
//  resetn      in   1                 synchronous, active-low reset
//  req         in   NREQ              client i requests a draw; held high until done[i]
//  rect_x0     in   NREQ*nX           per-client top-left x, client i at [i*nX +: nX]
//  rect_y0     in   NREQ*nY           per-client top-left y
//  rect_w      in   NREQ*nX           per-client width in pixels (0 = empty)
//  rect_h      in   NREQ*nY           per-client height in pixels (0 = empty)
//  rect_color  in   NREQ*COLOR_DEPTH  per-client fill colour
//  grant       out  NREQ              one-hot; high from latch cycle through the last DRAW cycle
//  done        out  NREQ              one-hot, 1-cycle pulse when client's rectangle is finished
//  busy        out  1                 high in any state other than IDLE
//  plot_x      out  nX                pixel x to adaptor
//  plot_y      out  nY                pixel y to adaptor
//  plot_color  out  COLOR_DEPTH       pixel colour to adaptor
//  plot        out  1                 write enable to adaptor; one pixel per cycle
// BEHAVIOUR
//  - Reset (resetn=0 at clock edge): state=IDLE; grant, done, busy, plot, plot_x, plot_y, plot_color = 0;
//    round-robin pointer = 0. Reset mid-draw aborts the command: no done pulse, no further plots.
//  - FSM states and transitions:
//    IDLE -> DRAW when any req is high; latches x0/y0/w/h/colour of the winner, sets grant, xc=yc=0.
//    DRAW -> DONE after the last pixel (xc=w-1, yc=h-1), or immediately if latched w==0 or h==0.
//    DONE -> IDLE; done[winner]=1 for this one cycle and grant=0.
//  - DRAW, one pixel per cycle, all outputs registered:
//    plot_x=x0+xc, plot_y=y0+yc, plot_color=colour, plot=1.
//    Counter order: xc counts 0..w-1; on wrap xc returns to 0 and yc increments.
//    Total plot cycles = w*h; a command takes w*h+2 cycles from the IDLE cycle to the DONE cycle.
//  - Width/clipping:
//    Sums x0+xc and y0+yc are computed at nX+1 / nY+1 bits.
//    If a sum is >= COLS/ROWS (or overflows), plot=0 for that cycle but scanning continues.
//    plot_x and plot_y carry the truncated sum.
//  - Arbitration is evaluated only in IDLE.
//    Priority starts at the pointer and searches upward, modulo NREQ.
//    After DONE, the pointer becomes winner+1 mod NREQ.
//  - Inputs are latched at grant.
//    Changes to rect_* or a dropped req during DRAW are ignored; the command completes.
//    A req still high in the cycle after done is treated as a new command.
//  - grant is held for exactly w*h cycles (1 cycle if the rectangle is empty); the DONE cycle is never back-to-back with a new DRAW.
//  - plot=0 in IDLE and DONE.
// STRUCTURE
//  - Shared include vga_draw_defs.vh holds:
//    * default nX, nY, COLOR_DEPTH, COLS, ROWS (shared with the adaptor and controller);
//    * state encodings S_IDLE=2'd0, S_DRAW=2'd1, S_DONE=2'd2.
//  - Sub-module rr_arbiter (NREQ): combinational one-hot pick from req and pointer, plus a pointer-update input.
//  - Top level holds the FSM, the latched command registers, the xc/yc counters and the output registers.
// TESTING
//  1. req[0] with x0=10, y0=20, w=3, h=2, colour=6'h30 ->
//     plots at (10,20) (11,20) (12,20) (10,21) (11,21) (12,21) on 6 consecutive cycles;
//     done[0] pulses on the next cycle.
//  2. req=2'b11 out of reset, both w=h=1 -> client 0 is served first; client 1 is granted in the
//     IDLE cycle after done[0]; done[1] follows 3 cycles after done[0].
//  3. req[1] with w=0, h=5 -> no plot; grant[1] high for 1 cycle; done[1] pulses 2 cycles after req is seen.
//  4. x0=158, w=4, y0=119, h=2 -> exactly 2 plots, (158,119) and (159,119); 8 DRAW cycles in total;
//     done pulses once.
//  5. resetn=0 mid-DRAW of a 4x4 rectangle -> next cycle plot=0, grant=0, busy=0; done is never asserted;
//     after reset, a held req restarts the command from (x0,y0).
//  6. Change rect_color and drop req[0] during DRAW -> all pixels keep the latched colour; done[0] still pulses.

Source files
------------

// File: rtl/rect_draw_sequencer_pkg.sv
// Shared definitions for the rectangle draw sequencer.
//   - Default geometry and colour depth, shared with the VGA adaptor and controller.
//   - Sequencer state encoding.
//   - idx_width(): width of a client index (at least one bit).
package rect_draw_sequencer_pkg;

  localparam int DEF_NX          = 8;
  localparam int DEF_NY          = 7;
  localparam int DEF_COLOR_DEPTH = 6;
  localparam int DEF_COLS        = 160;
  localparam int DEF_ROWS        = 120;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DRAW = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rect_draw_sequencer_rr_arbiter.sv
// Round-robin arbiter for the rectangle draw sequencer.
// Ports:
//   clock, resetn  system clock, synchronous active-low reset (pointer -> 0)
//   req            per-client request vector
//   advance        pulse: move the pointer to winner+1 (mod NREQ)
//   winner         index of the client that has just been served
//   pick           combinational one-hot choice, searching upward from the pointer
//   pick_idx       binary index of pick (0 when nothing is requested)
module rect_draw_sequencer_rr_arbiter
  import rect_draw_sequencer_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IW   = idx_width(NREQ)
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  input  logic [IW-1:0]   winner,
  output logic [NREQ-1:0] pick,
  output logic [IW-1:0]   pick_idx
);

  logic [IW-1:0] ptr;
  logic          found;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= IW'((int'(winner) + 1) % NREQ);
    end
  end

  // First requester at or above the pointer, wrapping modulo NREQ.
  always_comb begin
    pick     = '0;
    pick_idx = '0;
    found    = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[IW'((int'(ptr) + i) % NREQ)]) begin
        found                              = 1'b1;
        pick[IW'((int'(ptr) + i) % NREQ)]  = 1'b1;
        pick_idx                           = IW'((int'(ptr) + i) % NREQ);
      end
    end
  end

endmodule

// File: rtl/rect_draw_sequencer.sv
// Rectangle draw sequencer: shares the VGA adaptor write port between NREQ
// clients. A round-robin winner's filled rectangle is latched and scanned
// row-major, one registered pixel write per clock; off-screen pixels are
// suppressed (plot=0) while the scan carries on.
// Ports:
//   clock, resetn             system clock, synchronous active-low reset
//   req[NREQ]                 per-client draw request, held until done
//   rect_x0/y0/w/h/color      per-client command fields, client i at [i*W +: W]
//   grant[NREQ]               one-hot, high for every DRAW cycle of the command
//   done[NREQ]                one-hot, one-cycle pulse in the DONE cycle
//   busy                      state is not IDLE
//   plot_x/plot_y/plot_color  pixel to the adaptor
//   plot                      adaptor write enable
module rect_draw_sequencer
  import rect_draw_sequencer_pkg::*;
#(
  parameter int NREQ        = 2,
  parameter int nX          = DEF_NX,
  parameter int nY          = DEF_NY,
  parameter int COLOR_DEPTH = DEF_COLOR_DEPTH,
  parameter int COLS        = DEF_COLS,
  parameter int ROWS        = DEF_ROWS
) (
  input  logic                        clock,
  input  logic                        resetn,
  input  logic [NREQ-1:0]             req,
  input  logic [NREQ*nX-1:0]          rect_x0,
  input  logic [NREQ*nY-1:0]          rect_y0,
  input  logic [NREQ*nX-1:0]          rect_w,
  input  logic [NREQ*nY-1:0]          rect_h,
  input  logic [NREQ*COLOR_DEPTH-1:0] rect_color,
  output logic [NREQ-1:0]             grant,
  output logic [NREQ-1:0]             done,
  output logic                        busy,
  output logic [nX-1:0]               plot_x,
  output logic [nY-1:0]               plot_y,
  output logic [COLOR_DEPTH-1:0]      plot_color,
  output logic                        plot
);

  localparam int            IW     = idx_width(NREQ);
  localparam logic [nX:0]   COLS_L = COLS[nX:0];
  localparam logic [nY:0]   ROWS_L = ROWS[nY:0];
  localparam logic [nX-1:0] ONE_X  = {{(nX-1){1'b0}}, 1'b1};
  localparam logic [nY-1:0] ONE_Y  = {{(nY-1){1'b0}}, 1'b1};

  // Per-client command fields unpacked for indexing by the winner.
  logic [nX-1:0]          x0_arr    [NREQ];
  logic [nY-1:0]          y0_arr    [NREQ];
  logic [nX-1:0]          w_arr     [NREQ];
  logic [nY-1:0]          h_arr     [NREQ];
  logic [COLOR_DEPTH-1:0] color_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign x0_arr[g]    = rect_x0[g*nX +: nX];
    assign y0_arr[g]    = rect_y0[g*nY +: nY];
    assign w_arr[g]     = rect_w[g*nX +: nX];
    assign h_arr[g]     = rect_h[g*nY +: nY];
    assign color_arr[g] = rect_color[g*COLOR_DEPTH +: COLOR_DEPTH];
  end

  state_t                 state, state_next;
  logic [nX-1:0]          x0_q, x0_d, w_q, w_d, xc, xc_d, nxc;
  logic [nY-1:0]          y0_q, y0_d, h_q, h_d, yc, yc_d, nyc;
  logic [COLOR_DEPTH-1:0] color_q, color_d;
  logic [IW-1:0]          win_q, win_d;
  logic [NREQ-1:0]        grant_d, done_d;
  logic                   plot_d;
  logic [nX-1:0]          plot_x_d;
  logic [nY-1:0]          plot_y_d;
  logic [COLOR_DEPTH-1:0] plot_color_d;
  logic [nX:0]            sum_x;
  logic [nY:0]            sum_y;
  logic                   last_pix;
  logic                   advance;
  logic [NREQ-1:0]        pick;
  logic [IW-1:0]          pick_idx;

  // Sums are one bit wider than the coordinates, so an overflowing sum is
  // simply a large value and falls outside the screen.
  function automatic logic in_screen(input logic [nX:0] sx, input logic [nY:0] sy);
    return (sx < COLS_L) && (sy < ROWS_L);
  endfunction

  rect_draw_sequencer_rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .clock    (clock),
    .resetn   (resetn),
    .req      (req),
    .advance  (advance),
    .winner   (win_q),
    .pick     (pick),
    .pick_idx (pick_idx)
  );

  assign busy = (state != S_IDLE);

  // The output registers always hold the pixel of the current DRAW cycle, so
  // the pixel after the one being shown is computed here.
  always_comb begin
    state_next   = state;
    x0_d         = x0_q;
    y0_d         = y0_q;
    w_d          = w_q;
    h_d          = h_q;
    color_d      = color_q;
    win_d        = win_q;
    xc_d         = xc;
    yc_d         = yc;
    grant_d      = grant;
    done_d       = '0;
    plot_d       = 1'b0;
    plot_x_d     = plot_x;
    plot_y_d     = plot_y;
    plot_color_d = plot_color;
    advance      = 1'b0;
    nxc          = '0;
    nyc          = '0;
    sum_x        = '0;
    sum_y        = '0;
    last_pix     = (w_q == '0) || (h_q == '0) ||
                   ((xc == w_q - ONE_X) && (yc == h_q - ONE_Y));

    unique case (state)
      S_IDLE: begin
        if (|req) begin
          state_next   = S_DRAW;
          win_d        = pick_idx;
          grant_d      = pick;
          x0_d         = x0_arr[pick_idx];
          y0_d         = y0_arr[pick_idx];
          w_d          = w_arr[pick_idx];
          h_d          = h_arr[pick_idx];
          color_d      = color_arr[pick_idx];
          xc_d         = '0;
          yc_d         = '0;
          sum_x        = {1'b0, x0_arr[pick_idx]};
          sum_y        = {1'b0, y0_arr[pick_idx]};
          plot_x_d     = sum_x[nX-1:0];
          plot_y_d     = sum_y[nY-1:0];
          plot_color_d = color_arr[pick_idx];
          plot_d       = (w_arr[pick_idx] != '0) && (h_arr[pick_idx] != '0) &&
                         in_screen(sum_x, sum_y);
        end
      end
      S_DRAW: begin
        if (last_pix) begin
          state_next = S_DONE;
          grant_d    = '0;
          done_d     = grant;
        end else begin
          if (xc == w_q - ONE_X) begin
            nxc = '0;
            nyc = yc + ONE_Y;
          end else begin
            nxc = xc + ONE_X;
            nyc = yc;
          end
          xc_d     = nxc;
          yc_d     = nyc;
          sum_x    = {1'b0, x0_q} + {1'b0, nxc};
          sum_y    = {1'b0, y0_q} + {1'b0, nyc};
          plot_x_d = sum_x[nX-1:0];
          plot_y_d = sum_y[nY-1:0];
          plot_d   = in_screen(sum_x, sum_y);
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
        advance    = 1'b1;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state      <= S_IDLE;
      win_q      <= '0;
      grant      <= '0;
      done       <= '0;
      plot       <= 1'b0;
      plot_x     <= '0;
      plot_y     <= '0;
      plot_color <= '0;
    end else begin
      state      <= state_next;
      win_q      <= win_d;
      grant      <= grant_d;
      done       <= done_d;
      plot       <= plot_d;
      plot_x     <= plot_x_d;
      plot_y     <= plot_y_d;
      plot_color <= plot_color_d;
    end
  end

  // Latched command and scan counters; only meaningful while busy.
  always_ff @(posedge clock) begin
    x0_q    <= x0_d;
    y0_q    <= y0_d;
    w_q     <= w_d;
    h_q     <= h_d;
    color_q <= color_d;
    xc      <= xc_d;
    yc      <= yc_d;
  end

endmodule

// File: tb/tb_rect_draw_sequencer.sv
// Self-checking bench for rect_draw_sequencer: table of commands, hand-written
// arbitration and reset sequences, and random commands against a pixel model.
module tb_rect_draw_sequencer;

  localparam int NREQ = 2;
  localparam int NX   = 8;
  localparam int NY   = 7;
  localparam int CD   = 6;
  localparam int COLS = 160;
  localparam int ROWS = 120;

  logic                 clock = 1'b0;
  logic                 resetn;
  logic [NREQ-1:0]      req;
  logic [NREQ*NX-1:0]   rect_x0;
  logic [NREQ*NY-1:0]   rect_y0;
  logic [NREQ*NX-1:0]   rect_w;
  logic [NREQ*NY-1:0]   rect_h;
  logic [NREQ*CD-1:0]   rect_color;
  logic [NREQ-1:0]      grant;
  logic [NREQ-1:0]      done;
  logic                 busy;
  logic [NX-1:0]        plot_x;
  logic [NY-1:0]        plot_y;
  logic [CD-1:0]        plot_color;
  logic                 plot;

  int n_checks = 0;
  int n_fail   = 0;

  rect_draw_sequencer #(
    .NREQ(NREQ), .nX(NX), .nY(NY), .COLOR_DEPTH(CD), .COLS(COLS), .ROWS(ROWS)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .req        (req),
    .rect_x0    (rect_x0),
    .rect_y0    (rect_y0),
    .rect_w     (rect_w),
    .rect_h     (rect_h),
    .rect_color (rect_color),
    .grant      (grant),
    .done       (done),
    .busy       (busy),
    .plot_x     (plot_x),
    .plot_y     (plot_y),
    .plot_color (plot_color),
    .plot       (plot)
  );

  always #5 clock = ~clock;

  typedef struct {
    int c;
    int x0;
    int y0;
    int w;
    int h;
    int col;
    int mut;
    int exp_plots;
    int exp_cycles;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_client(input int c, input int x0, input int y0, input int w,
                            input int h, input int col);
    rect_x0[c*NX +: NX]    = NX'(x0);
    rect_y0[c*NY +: NY]    = NY'(y0);
    rect_w[c*NX +: NX]     = NX'(w);
    rect_h[c*NY +: NY]     = NY'(h);
    rect_color[c*CD +: CD] = CD'(col);
  endtask

  // Number of on-screen pixels in the rectangle.
  function automatic int model_plots(input int x0, input int y0, input int w, input int h);
    int n = 0;
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        if ((x0 + c) < COLS && (y0 + r) < ROWS) n++;
    return n;
  endfunction

  // Issue one command from an idle DUT (called at a negedge) and follow it to
  // done. Each cycle with grant high is compared with pixel k of the row-major
  // scan. With mut set, colour and req change after the first pixel.
  task automatic run_cmd(input int c, input int x0, input int y0, input int w, input int h,
                         input int col, input int mut, input string tag,
                         output int cycles, output int plots);
    int  n, cc, rr;
    bit  ep;
    n      = (w * h == 0) ? 1 : w * h;
    cycles = 0;
    plots  = 0;
    set_client(c, x0, y0, w, h, col);
    req = NREQ'(1 << c);
    @(negedge clock);
    while (done == '0 && cycles < 300) begin
      if (cycles < n) begin
        cc = (w * h == 0) ? 0 : cycles % w;
        rr = (w * h == 0) ? 0 : cycles / w;
        ep = (w * h != 0) && ((x0 + cc) < COLS) && ((y0 + rr) < ROWS);
        chk({tag, " grant"}, 32'(grant), 32'(1 << c));
        chk({tag, " plot"}, 32'(plot), 32'(ep));
        if (ep) begin
          chk({tag, " plot_x"}, 32'(plot_x), 32'((x0 + cc) % (1 << NX)));
          chk({tag, " plot_y"}, 32'(plot_y), 32'((y0 + rr) % (1 << NY)));
          chk({tag, " plot_color"}, 32'(plot_color), 32'(col));
        end
      end
      if (plot) plots++;
      if (mut != 0 && cycles == 0) begin
        rect_color[c*CD +: CD] = CD'(col ^ 63);
        req = '0;
      end
      cycles++;
      @(negedge clock);
    end
    chk({tag, " done"}, 32'(done), 32'(1 << c));
    chk({tag, " grant in DONE"}, 32'(grant), 32'(0));
    chk({tag, " plot in DONE"}, 32'(plot), 32'(0));
    req = '0;
    @(negedge clock);
    chk({tag, " done one cycle"}, 32'(done), 32'(0));
    chk({tag, " idle busy"}, 32'(busy), 32'(0));
  endtask

  initial begin
    int cyc, npl;
    int c, x0, y0, w, h, col;

    tbl[0] = '{0,  10,  20,  3, 2, 'h30, 0, 6, 6};
    tbl[1] = '{1,   7,   9,  0, 5, 'h0A, 0, 0, 1};
    tbl[2] = '{0, 158, 119,  4, 2, 'h2C, 0, 2, 8};
    tbl[3] = '{1,   0,   0,  1, 1, 'h3F, 0, 1, 1};
    tbl[4] = '{0, 159,   0,  2, 1, 'h01, 0, 1, 2};
    tbl[5] = '{1, 250,  10, 10, 1, 'h12, 0, 0, 10};
    tbl[6] = '{0,   0, 119,  3, 3, 'h07, 0, 3, 9};
    tbl[7] = '{0,  30,  40,  3, 3, 'h15, 1, 9, 9};
    tbl[8] = '{1,   5, 126,  2, 3, 'h20, 0, 0, 6};
    tbl[9] = '{1, 100, 100,  5, 0, 'h11, 0, 0, 1};

    resetn     = 1'b0;
    req        = '0;
    rect_x0    = '0;
    rect_y0    = '0;
    rect_w     = '0;
    rect_h     = '0;
    rect_color = '0;
    repeat (3) @(negedge clock);
    chk("reset grant", 32'(grant), 32'(0));
    chk("reset done", 32'(done), 32'(0));
    chk("reset busy", 32'(busy), 32'(0));
    chk("reset plot", 32'(plot), 32'(0));
    chk("reset plot_x", 32'(plot_x), 32'(0));
    chk("reset plot_y", 32'(plot_y), 32'(0));
    chk("reset plot_color", 32'(plot_color), 32'(0));

    // Both clients request out of reset: 0 first, then 1 right after.
    resetn = 1'b1;
    set_client(0, 1, 1, 1, 1, 'h05);
    set_client(1, 2, 2, 1, 1, 'h06);
    req = 2'b11;
    @(negedge clock);
    chk("rr grant0", 32'(grant), 32'h1);
    chk("rr plot0", 32'(plot), 32'h1);
    chk("rr x0", 32'(plot_x), 32'd1);
    @(negedge clock);
    chk("rr done0", 32'(done), 32'h1);
    @(negedge clock);
    chk("rr idle grant", 32'(grant), 32'h0);
    chk("rr idle busy", 32'(busy), 32'h0);
    chk("rr idle done", 32'(done), 32'h0);
    @(negedge clock);
    chk("rr grant1", 32'(grant), 32'h2);
    chk("rr x1", 32'(plot_x), 32'd2);
    chk("rr color1", 32'(plot_color), 32'h06);
    @(negedge clock);
    chk("rr done1", 32'(done), 32'h2);
    req = '0;
    @(negedge clock);
    chk("rr final busy", 32'(busy), 32'h0);

    for (int i = 0; i < 10; i++) begin
      run_cmd(tbl[i].c, tbl[i].x0, tbl[i].y0, tbl[i].w, tbl[i].h, tbl[i].col, tbl[i].mut,
              $sformatf("vec%0d", i), cyc, npl);
      chk($sformatf("vec%0d cycles", i), 32'(cyc), 32'(tbl[i].exp_cycles));
      chk($sformatf("vec%0d plots", i), 32'(npl), 32'(tbl[i].exp_plots));
    end

    // Reset in the middle of a 4x4 draw, req held throughout.
    set_client(0, 5, 5, 4, 4, 'h11);
    req = 2'b01;
    @(negedge clock);
    repeat (4) @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    chk("abort plot", 32'(plot), 32'h0);
    chk("abort grant", 32'(grant), 32'h0);
    chk("abort busy", 32'(busy), 32'h0);
    chk("abort done", 32'(done), 32'h0);
    resetn = 1'b1;
    @(negedge clock);
    chk("restart grant", 32'(grant), 32'h1);
    chk("restart plot", 32'(plot), 32'h1);
    chk("restart x", 32'(plot_x), 32'd5);
    chk("restart y", 32'(plot_y), 32'd5);
    for (int i = 1; i < 16; i++) begin
      @(negedge clock);
      chk("restart no early done", 32'(done), 32'h0);
    end
    @(negedge clock);
    chk("restart done", 32'(done), 32'h1);
    req = '0;
    @(negedge clock);
    chk("restart idle", 32'(busy), 32'h0);

    for (int i = 0; i < 30; i++) begin
      c   = int'($urandom_range(0, 1));
      x0  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(150, 255)) : int'($urandom_range(0, 159));
      y0  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(110, 127)) : int'($urandom_range(0, 119));
      w   = int'($urandom_range(0, 6));
      h   = int'($urandom_range(0, 4));
      col = int'($urandom_range(0, 63));
      run_cmd(c, x0, y0, w, h, col, 0, $sformatf("rnd%0d", i), cyc, npl);
      chk($sformatf("rnd%0d cycles", i), 32'(cyc), 32'((w * h == 0) ? 1 : w * h));
      chk($sformatf("rnd%0d plots", i), 32'(npl), 32'(model_plots(x0, y0, w, h)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
